vote_round_ctrl: RTL and testbench

Sequencer for the five-input vote display path: opens a voting round, collects at most one vote per voter from five independent voters, closes the round when all have voted or a timeout expires, and then presents the latched vote vector on `comps` to the seven-segment vote decoder for a fixed display interval. Sits between the voter inputs and the existing `comps[4:0]` → `segs[6:0]` decoder, which stays purely combinational; this block adds all round timing and bookkeeping.

---
 rtl/vote_round_ctrl.sv | 167 ++++++++++++++++
 tb/tb_vote_round_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_round_ctrl.sv
// vote_round_ctrl: opens a voting round, collects at most one vote per voter
// from five voters, closes on full participation or timeout, then presents
// the latched vote vector on comps for a fixed display interval.
//
// Vote strobes: vote_valid[i] is a single-cycle qualifier for vote_value[i].
// There is no ready/back-pressure path. A strobe is consumed only in COLLECT
// and only while voted[i] is still 0. The first strobe from a voter wins, and
// any later strobe from that voter in the same round is dropped silently.
module vote_round_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLD_CYCLES    = 500,
  parameter int ROUND_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4:0]         vote_valid,
  input  logic [4:0]         vote_value,
  output logic [4:0]         comps,
  output logic               disp_en,
  output logic               collecting,
  output logic [4:0]         voted,
  output logic [2:0]         yes_count,
  output logic               round_done,
  output logic               timed_out,
  output logic [ROUND_W-1:0] rounds,
  output logic [1:0]         dbg_state
);

  // Counters are sized to hold the last in-state count, with at least one bit.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_SHOW    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [4:0]         vote_q, vote_d;
  logic [4:0]         voted_q, voted_d;
  logic [4:0]         comps_q, comps_d;
  logic [2:0]         yes_q, yes_d;
  logic               round_done_q, round_done_d;
  logic               timed_out_q, timed_out_d;
  logic [ROUND_W-1:0] rounds_q, rounds_d;

  // Voters accepted this cycle, and the vote/mask they produce.
  logic [4:0] accept;
  logic [4:0] voted_next;
  logic [4:0] vote_next;
  logic       full;
  logic       tmo_last;

  function automatic logic [2:0] popcnt5(input logic [4:0] v);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 5; i++) begin
      s = s + {2'b00, v[i]};
    end
    return s;
  endfunction

  // Per-cycle vote merge: only first-time voters update the vote register.
  always_comb begin
    accept     = vote_valid & ~voted_q;
    voted_next = voted_q | accept;
    vote_next  = (vote_q & ~accept) | (vote_value & accept);
    full       = (voted_next == 5'h1F);
    tmo_last   = (timer_q == TIMER_LAST);
  end

  // Next-state and register updates for the round sequencer.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    hold_d       = hold_q;
    vote_d       = vote_q;
    voted_d      = voted_q;
    comps_d      = comps_q;
    yes_d        = yes_q;
    round_done_d = 1'b0;
    timed_out_d  = timed_out_q;
    rounds_d     = rounds_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          timer_d = '0;
          vote_d  = 5'd0;
          voted_d = 5'd0;
        end
      end
      S_COLLECT: begin
        vote_d  = vote_next;
        voted_d = voted_next;
        timer_d = timer_q + TW'(1);
        // Full participation takes priority over a coincident timeout.
        if (full || tmo_last) begin
          state_d      = S_SHOW;
          hold_d       = '0;
          comps_d      = vote_next;
          yes_d        = popcnt5(vote_next);
          rounds_d     = rounds_q + ROUND_W'(1);
          round_done_d = 1'b1;
          timed_out_d  = ~full;
        end
      end
      S_SHOW: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any round in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      hold_q       <= '0;
      vote_q       <= 5'd0;
      voted_q      <= 5'd0;
      comps_q      <= 5'd0;
      yes_q        <= 3'd0;
      round_done_q <= 1'b0;
      timed_out_q  <= 1'b0;
      rounds_q     <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      hold_q       <= hold_d;
      vote_q       <= vote_d;
      voted_q      <= voted_d;
      comps_q      <= comps_d;
      yes_q        <= yes_d;
      round_done_q <= round_done_d;
      timed_out_q  <= timed_out_d;
      rounds_q     <= rounds_d;
    end
  end

  // All outputs come straight from registers (state decode is of state_q only).
  always_comb begin
    comps      = comps_q;
    disp_en    = (state_q == S_SHOW);
    collecting = (state_q == S_COLLECT);
    voted      = voted_q;
    yes_count  = yes_q;
    round_done = round_done_q;
    timed_out  = timed_out_q;
    rounds     = rounds_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_vote_round_ctrl.sv
// tb_vote_round_ctrl: directed vectors with hand-computed expectations for
// vote_round_ctrl, built with TIMEOUT_CYCLES=8, HOLD_CYCLES=4 and ROUND_W=2.
module tb_vote_round_ctrl;

  localparam int TMO  = 8;
  localparam int HOLD = 4;
  localparam int RW   = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [4:0]    vote_valid;
  logic [4:0]    vote_value;
  logic [4:0]    comps;
  logic          disp_en;
  logic          collecting;
  logic [4:0]    voted;
  logic [2:0]    yes_count;
  logic          round_done;
  logic          timed_out;
  logic [RW-1:0] rounds;
  logic [1:0]    dbg_state;

  int n_total;
  int n_bad;

  vote_round_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .HOLD_CYCLES   (HOLD),
    .ROUND_W       (RW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vote_valid(vote_valid),
    .vote_value(vote_value),
    .comps     (comps),
    .disp_en   (disp_en),
    .collecting(collecting),
    .voted     (voted),
    .yes_count (yes_count),
    .round_done(round_done),
    .timed_out (timed_out),
    .rounds    (rounds),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs and samples both sit 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic vote(input logic [4:0] v, input logic [4:0] val);
    vote_valid = v;
    vote_value = val;
    tick();
    vote_valid = 5'd0;
    vote_value = 5'd0;
  endtask

  // Run out the rest of SHOW; returns number of further disp_en cycles seen.
  task automatic wait_idle(output int seen);
    int guard;
    seen  = 0;
    guard = 0;
    while (disp_en && guard < 50) begin
      tick();
      guard++;
      if (disp_en) seen++;
    end
    chk("idle_wait", {31'd0, disp_en}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_comps"},      {27'd0, comps},      32'd0);
    chk({pfx, "_disp_en"},    {31'd0, disp_en},    32'd0);
    chk({pfx, "_collecting"}, {31'd0, collecting}, 32'd0);
    chk({pfx, "_voted"},      {27'd0, voted},      32'd0);
    chk({pfx, "_yes"},        {29'd0, yes_count},  32'd0);
    chk({pfx, "_round_done"}, {31'd0, round_done}, 32'd0);
    chk({pfx, "_timed_out"},  {31'd0, timed_out},  32'd0);
    chk({pfx, "_rounds"},     {30'd0, rounds},     32'd0);
  endtask

  // ---------------- stimulus + scoreboard ----------------
  logic [RW-1:0] exp_q[$];

  initial begin
    int seen;
    n_total    = 0;
    n_bad      = 0;
    rst        = 1'b1;
    start      = 1'b0;
    vote_valid = 5'd0;
    vote_value = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_vals("rst0");

    // Expected rounds values after each completed round (ROUND_W=2 wraps).
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);

    // Round 1: separate-cycle votes 1,0,1,0,1 from voters 0..4.
    do_start();
    chk("r1_collecting", {31'd0, collecting}, 32'd1);
    vote(5'b00001, 5'b00001);
    chk("r1_voted0", {27'd0, voted}, 32'h01);
    vote(5'b00010, 5'b00000);
    vote(5'b00100, 5'b00100);
    vote(5'b01000, 5'b00000);
    chk("r1_not_done", {31'd0, round_done}, 32'd0);
    vote(5'b10000, 5'b10000);
    chk("r1_round_done", {31'd0, round_done}, 32'd1);
    chk("r1_comps",      {27'd0, comps},      32'h15);
    chk("r1_yes",        {29'd0, yes_count},  32'd3);
    chk("r1_timed_out",  {31'd0, timed_out},  32'd0);
    chk("r1_collect_lo", {31'd0, collecting}, 32'd0);
    chk("r1_rounds",     {30'd0, rounds},     {30'd0, exp_q.pop_front()});
    tick();
    chk("r1_pulse_once", {31'd0, round_done}, 32'd0);
    wait_idle(seen);
    chk("r1_hold_len", seen + 2, HOLD);

    // Round 2: everyone votes yes in one cycle.
    do_start();
    vote(5'h1F, 5'h1F);
    chk("r2_disp_en", {31'd0, disp_en},   32'd1);
    chk("r2_comps",   {27'd0, comps},     32'h1F);
    chk("r2_yes",     {29'd0, yes_count}, 32'd5);
    chk("r2_rounds",  {30'd0, rounds},    {30'd0, exp_q.pop_front()});
    wait_idle(seen);

    // Round 3: only voter 1 votes, round times out after 8 COLLECT cycles.
    do_start();
    for (int k = 1; k <= TMO; k++) begin
      if (k == 1) begin
        vote_valid = 5'b00010;
        vote_value = 5'b00010;
      end
      tick();
      vote_valid = 5'd0;
      vote_value = 5'd0;
      if (k == TMO - 1) chk("r3_still_coll", {31'd0, collecting}, 32'd1);
    end
    chk("r3_round_done", {31'd0, round_done}, 32'd1);
    chk("r3_comps",      {27'd0, comps},      32'h02);
    chk("r3_voted",      {27'd0, voted},      32'h02);
    chk("r3_timed_out",  {31'd0, timed_out},  32'd1);
    chk("r3_rounds",     {30'd0, rounds},     {30'd0, exp_q.pop_front()});
    wait_idle(seen);
    chk("r3_tmo_kept",   {31'd0, timed_out},  32'd1);

    // Round 4: as above, plus voter 3 votes 1 in the final COLLECT cycle.
    do_start();
    for (int k = 1; k <= TMO; k++) begin
      if (k == 1) begin
        vote_valid = 5'b00010;
        vote_value = 5'b00010;
      end
      if (k == TMO) begin
        vote_valid = 5'b01000;
        vote_value = 5'b01000;
      end
      tick();
      vote_valid = 5'd0;
      vote_value = 5'd0;
    end
    chk("r4_comps",     {27'd0, comps},     32'h0A);
    chk("r4_voted",     {27'd0, voted},     32'h0A);
    chk("r4_yes",       {29'd0, yes_count}, 32'd2);
    chk("r4_timed_out", {31'd0, timed_out}, 32'd1);
    chk("r4_rounds",    {30'd0, rounds},    {30'd0, exp_q.pop_front()});
    wait_idle(seen);

    // Round 5: voter 2 re-votes, start pulsed in COLLECT and SHOW.
    do_start();
    vote(5'b00100, 5'b00100);
    start = 1'b1;
    vote(5'b00100, 5'b00000);
    start = 1'b0;
    chk("r5_first_wins", {27'd0, voted}, 32'h04);
    vote(5'b11011, 5'b00000);
    chk("r5_comps",  {27'd0, comps},  32'h04);
    chk("r5_rounds", {30'd0, rounds}, {30'd0, exp_q.pop_front()});
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r5_show_hold", {31'd0, disp_en}, 32'd1);
    wait_idle(seen);
    tick();
    chk("r5_no_restart", {31'd0, collecting}, 32'd0);
    chk("r5_rounds_once", {30'd0, rounds}, 32'd1);

    // Reset mid-round with four votes in.
    do_start();
    vote(5'b01111, 5'b00101);
    chk("r6_voted4", {27'd0, voted}, 32'h0F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("r6_rst");
    tick();
    chk("r6_no_round", {30'd0, rounds}, 32'd0);

    // Round after reset behaves normally.
    do_start();
    vote(5'h1F, 5'b00011);
    chk("r7_round_done", {31'd0, round_done}, 32'd1);
    chk("r7_comps",      {27'd0, comps},      32'h03);
    chk("r7_yes",        {29'd0, yes_count},  32'd2);
    chk("r7_rounds",     {30'd0, rounds},     32'd1);
    wait_idle(seen);

    chk("exp_q_drained", exp_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
